// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier.
// Holds the FSM state encoding, the counter-width helper and the overflow test.
package mult_pkg;

   // FSM states of the multiplier
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Widest operand the overflow helper can examine (products up to 2*MAX_W bits)
   localparam int MAX_W = 64;

   // Iteration counter width for an N-bit operand
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // True when an n-bit-operand product (zero-extended into prod) does not fit
   // back into n bits: signed needs bits [2n-1:n-1] all equal, unsigned needs [2n-1:n] zero
   function automatic logic ovf_check(input logic [2*MAX_W-1:0] prod,
                                      input int n,
                                      input logic sgn);
      logic all0;
      logic all1;
      int   lo;
      all0 = 1'b1;
      all1 = 1'b1;
      lo   = sgn ? n - 1 : n;
      for (int i = 0; i < 2*MAX_W; i++) begin
         if (i >= lo && i < 2*n) begin
            all0 = all0 & ~prod[i];
            all1 = all1 & prod[i];
         end
      end
      return sgn ? ~(all0 | all1) : ~all0;
   endfunction

endpackage

// File: rtl/shift_add_step.sv
// One shift-add iteration: conditionally add the multiplicand magnitude into the
// accumulator half of P, then shift the whole of P right by one bit.
// P is {acc[N:0], multiplier[N-1:0]}; the N+1-bit accumulator keeps the add carry.
module shift_add_step #(
   parameter int N = 32
) (
   input  logic [2*N:0] p,
   input  logic [N-1:0] mcand,
   output logic [2*N:0] p_next
);

   logic [N:0] acc_sum;

   // Add on multiplier LSB, then shift right with a zero entering at the top
   always_comb begin
      acc_sum = p[2*N:N] + (p[0] ? {1'b0, mcand} : {(N+1){1'b0}});
      p_next  = {1'b0, acc_sum, p[N-1:1]};
   end

endmodule

// File: rtl/pipelined_seq_multiplier.sv
// Multi-cycle shift-add multiplier, one multiplier bit retired per clock.
// Operands are reduced to magnitudes on accept, multiplied unsigned, and the
// sign is reapplied in a single FIX cycle together with the overflow check.
// Valid for 4 <= N <= mult_pkg::MAX_W.
module pipelined_seq_multiplier
   import mult_pkg::*;
#(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_signed,
   input  logic [N-1:0]   in1,
   input  logic [N-1:0]   in2,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out,
   output logic           ovflag
);

   localparam int CW = cnt_width(N);

   state_t         state;
   state_t         state_next;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   mcand;
   logic [2*N:0]   prod;
   logic [2*N:0]   prod_step;
   logic           neg;
   logic           sgn;
   logic [N-1:0]   mag1;
   logic [N-1:0]   mag2;
   logic [2*N-1:0] mag_prod;
   logic [2*N-1:0] result;
   logic           result_ovf;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Operand magnitudes; -2^(N-1) maps to 2^(N-1), which still fits in N unsigned bits
   always_comb begin
      mag1 = (in_signed && in1[N-1]) ? -in1 : in1;
      mag2 = (in_signed && in2[N-1]) ? -in2 : in2;
   end

   // Reapply the sign to the unsigned product and judge whether it fits in N bits
   always_comb begin
      mag_prod   = prod[2*N-1:0];
      result     = neg ? -mag_prod : mag_prod;
      result_ovf = ovf_check((2*MAX_W)'(result), N, sgn);
   end

   shift_add_step #(.N(N)) u_step (
      .p      (prod),
      .mcand  (mcand),
      .p_next (prod_step)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state decode: N busy iterations, one fix-up cycle, then hold until consumed
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = BUSY;
         BUSY:    if (cnt == CW'(N-1)) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture on accept, iterate while busy, register the signed result in FIX
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         mcand  <= '0;
         prod   <= '0;
         neg    <= 1'b0;
         sgn    <= 1'b0;
         out    <= '0;
         ovflag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand <= mag1;
                  prod  <= {{(N+1){1'b0}}, mag2};
                  neg   <= in_signed & (in1[N-1] ^ in2[N-1]);
                  sgn   <= in_signed;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               prod <= prod_step;
               cnt  <= cnt + 1'b1;
            end
            FIX: begin
               out    <= result;
               ovflag <= result_ovf;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipelined_seq_multiplier.sv
// Self-checking bench for pipelined_seq_multiplier at N=32 and N=8.
// Expected products come from plain integer arithmetic on the operands.
module tb_pipelined_seq_multiplier;

   localparam int NA = 32;
   localparam int NB = 8;

   logic clk = 1'b0;
   logic rst;

   logic        a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready, a_ovflag;
   logic [31:0] a_in1, a_in2;
   logic [63:0] a_out;

   logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_ovflag;
   logic [7:0]  b_in1, b_in2;
   logic [15:0] b_out;

   int testCount = 0;
   int failCount = 0;

   // Free-running clock
   always #5 clk = ~clk;

   pipelined_seq_multiplier #(.N(NA)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_signed (a_in_signed),
      .in1       (a_in1),
      .in2       (a_in2),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out       (a_out),
      .ovflag    (a_ovflag)
   );

   pipelined_seq_multiplier #(.N(NB)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_signed (b_in_signed),
      .in1       (b_in1),
      .in2       (b_in2),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out       (b_out),
      .ovflag    (b_ovflag)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Product and overflow computed from integer arithmetic on w-bit operands
   function automatic void refModel(input int w, input logic sgn,
                                    input logic [31:0] x, input logic [31:0] y,
                                    output logic [63:0] prod, output logic ovf);
      longint unsigned ux, uy, up, mask;
      longint sx, sy, sp, lim;
      mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      ux = {32'b0, x} & mask;
      uy = {32'b0, y} & mask;
      if (sgn) begin
         lim = longint'(1) << (w - 1);
         sx  = ux[w-1] ? $signed(ux) - (lim <<< 1) : $signed(ux);
         sy  = uy[w-1] ? $signed(uy) - (lim <<< 1) : $signed(uy);
         sp  = sx * sy;
         ovf = (sp < -lim) || (sp >= lim);
         up  = $unsigned(sp);
      end else begin
         up  = ux * uy;
         ovf = (up >> w) != 0;
      end
      if (w == 32) prod = up;
      else         prod = up & ((64'd1 << (2*w)) - 64'd1);
   endfunction

   function automatic logic [63:0] getOut(input int w);
      return (w == NA) ? a_out : {48'b0, b_out};
   endfunction

   function automatic logic getValid(input int w);
      return (w == NA) ? a_out_valid : b_out_valid;
   endfunction

   function automatic logic getReady(input int w);
      return (w == NA) ? a_in_ready : b_in_ready;
   endfunction

   function automatic logic getOv(input int w);
      return (w == NA) ? a_ovflag : b_ovflag;
   endfunction

   task automatic driveIn(input int w, input logic v, input logic s,
                          input logic [31:0] x, input logic [31:0] y);
      if (w == NA) begin
         a_in_valid = v; a_in_signed = s; a_in1 = x; a_in2 = y;
      end else begin
         b_in_valid = v; b_in_signed = s; b_in1 = x[7:0]; b_in2 = y[7:0];
      end
   endtask

   task automatic setOutReady(input int w, input logic r);
      if (w == NA) a_out_ready = r;
      else         b_out_ready = r;
   endtask

   // Waits (bounded) for out_valid after an accept edge, scrambling the
   // operand inputs each cycle to show they are ignored; returns cycles taken
   task automatic waitDone(input int w, output int cyc);
      cyc = 0;
      while (!getValid(w) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         driveIn(w, 1'b0, 1'($urandom), $urandom, $urandom);
      end
   endtask

   // One full transaction: accept, wait, compare, consume
   task automatic applyStimulus(input int w, input logic sgn,
                                input logic [31:0] x, input logic [31:0] y,
                                input string tag);
      logic [63:0] ep;
      logic        eo;
      int          cyc;
      refModel(w, sgn, x, y, ep, eo);
      @(negedge clk);
      checkOutput({tag, " in_ready idle"}, getReady(w), 1);
      driveIn(w, 1'b1, sgn, x, y);
      @(posedge clk); #1;
      driveIn(w, 1'b0, 1'($urandom), $urandom, $urandom);
      checkOutput({tag, " in_ready busy"}, getReady(w), 0);
      waitDone(w, cyc);
      checkOutput({tag, " latency"}, cyc, w + 1);
      checkOutput({tag, " out"}, getOut(w), ep);
      checkOutput({tag, " ovflag"}, getOv(w), eo);
      @(negedge clk);
      setOutReady(w, 1'b1);
      @(posedge clk); #1;
      setOutReady(w, 1'b0);
      checkOutput({tag, " back to idle"}, getReady(w), 1);
      checkOutput({tag, " valid dropped"}, getValid(w), 0);
   endtask

   // Guards against a hung handshake
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] ep;
      logic        eo;
      logic [31:0] x, y;
      int          cyc;
      int          w;

      rst = 1'b0;
      driveIn(NA, 1'b0, 1'b0, 32'h0, 32'h0);
      driveIn(NB, 1'b0, 1'b0, 32'h0, 32'h0);
      a_out_ready = 1'b0;
      b_out_ready = 1'b0;
      #12;
      checkOutput("reset out", a_out, 64'h0);
      checkOutput("reset ovflag", a_ovflag, 0);
      checkOutput("reset out_valid", a_out_valid, 0);
      checkOutput("reset in_ready", a_in_ready, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Directed cases
      applyStimulus(NA, 1'b1, 32'hFFFF_FFFD, 32'h7, "neg3x7");
      checkOutput("neg3x7 const", a_out, 64'hFFFF_FFFF_FFFF_FFEB);
      applyStimulus(NA, 1'b1, 32'h8000_0000, 32'h8000_0000, "minxmin");
      checkOutput("minxmin const", a_out, 64'h4000_0000_0000_0000);
      checkOutput("minxmin ovf const", a_ovflag, 1);
      applyStimulus(NA, 1'b1, 32'h0, 32'h8000_0000, "zeroxmin");
      applyStimulus(NA, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones unsigned");
      checkOutput("ones unsigned const", a_out, 64'hFFFF_FFFE_0000_0001);
      applyStimulus(NA, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones signed");
      checkOutput("ones signed const", a_out, 64'h1);
      applyStimulus(NB, 1'b1, 32'h7F, 32'h7F, "n8 7fx7f");
      checkOutput("n8 7fx7f const", {48'b0, b_out}, 64'h3F01);
      applyStimulus(NB, 1'b1, 32'h05, 32'hFD, "n8 5xneg3");
      checkOutput("n8 5xneg3 const", {48'b0, b_out}, 64'hFFF1);

      // Backpressure: result held, inputs ignored while DONE waits for out_ready
      refModel(NA, 1'b0, 32'd12345, 32'd6789, ep, eo);
      @(negedge clk);
      driveIn(NA, 1'b1, 1'b0, 32'd12345, 32'd6789);
      @(posedge clk); #1;
      driveIn(NA, 1'b0, 1'b0, 32'h0, 32'h0);
      waitDone(NA, cyc);
      checkOutput("bp latency", cyc, NA + 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         driveIn(NA, 1'b1, 1'b1, $urandom, $urandom);
         @(posedge clk); #1;
         checkOutput("bp out held", a_out, ep);
         checkOutput("bp ovflag held", a_ovflag, eo);
         checkOutput("bp in_ready low", a_in_ready, 0);
         checkOutput("bp valid held", a_out_valid, 1);
      end
      @(negedge clk);
      driveIn(NA, 1'b0, 1'b0, 32'h0, 32'h0);
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      checkOutput("bp release idle", a_in_ready, 1);
      applyStimulus(NA, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, "bp follow-up");

      // Reset in the middle of BUSY abandons the operation at once
      @(negedge clk);
      driveIn(NA, 1'b1, 1'b0, 32'h0001_0001, 32'h0003_0003);
      @(posedge clk); #1;
      driveIn(NA, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midreset out", a_out, 64'h0);
      checkOutput("midreset out_valid", a_out_valid, 0);
      checkOutput("midreset ovflag", a_ovflag, 0);
      checkOutput("midreset in_ready", a_in_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(NA, 1'b0, 32'd5, 32'd6, "after reset");
      checkOutput("after reset const", a_out, 64'd30);

      // Randomised operands, biased toward zero, most-negative and all-ones
      for (int i = 0; i < 40; i++) begin
         w = (i % 2 == 0) ? NA : NB;
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 5))
            0: x = 32'h0;
            1: x = (w == NA) ? 32'h8000_0000 : 32'h80;
            2: y = 32'hFFFF_FFFF;
            default: ;
         endcase
         applyStimulus(w, 1'($urandom), x, y, "random");
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/pipelined_seq_multiplier.md
# pipelined_seq_multiplier

Parametrised multi-cycle shift-add multiplier. It supports signed or unsigned mode per operation and uses a valid/ready handshake on input and output. It replaces the single-cycle unrolled multiplier in the arithmetic datapath. It retires one multiplier bit per clock, so area stays small and the critical path short for any width, and it produces a registered 2N-bit product with a true N-bit overflow flag.

## Interface
- N, 32: operand width in bits; N ≥ 4.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are valid this cycle.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched on accept.
- in1  in  N  multiplicand.
- in2  in  N  multiplier.
- out_valid  out  1  product valid; held until consumed.
- out_ready  in  1  consumer takes the product.
- out  out  2N  product.
- ovflag  out  1  product does not fit in N bits of the selected signedness.

## Operation
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture the operands and go to BUSY.
  - Capture stores |in1| and |in2| (magnitudes when in_signed, raw values otherwise), the sign neg = in_signed & (in1[N-1] ^ in2[N-1]), and in_signed.
  - Capture clears the accumulator and the counter.
- BUSY, one iteration per cycle:
  - Product register P is 2N+1 bits: {acc[N:0], multiplier[N-1:0]}.
  - If P[0] = 1, add the multiplicand magnitude to acc.
  - Then shift P right by 1.
  - After N iterations (count = N-1), go to FIX.
- FIX, one cycle:
  - out = neg ? two's complement of the magnitude : magnitude.
  - Compute ovflag from the final out.
  - Go to DONE.
- DONE:
  - out_valid = 1; out and ovflag stable.
  - When out_ready is sampled high, go to IDLE.
- Overflow:
  - Signed mode: ovflag = 1 unless out[2N-1:N-1] are all equal.
  - Unsigned mode: ovflag = 1 unless out[2N-1:N] = 0.
  - A zero operand always gives out = 0 and ovflag = 0.
- Width rules:
  - The magnitude of -2^(N-1) is 2^(N-1), which fits in N unsigned bits.
  - The accumulator is N+1 bits so the add carry is never lost.
  - A 2N-bit two's complement is exact for every result.
- in1, in2 and in_signed are ignored outside IDLE; changes during BUSY or FIX have no effect.
- out and ovflag keep their last value in IDLE until the next FIX.

## Timing
- Reset values: state IDLE, out 0, ovflag 0, out_valid 0, all internal registers 0. in_ready is 1 during reset (it is decoded from state), but inputs are not sampled while rst is low.
- Reset asserted at any point, including mid-BUSY, FIX or DONE: the operation is abandoned immediately and asynchronously, with no partial result. The first accept is possible on the first rising edge after rst deasserts.
- Accept happens on the edge where in_valid & in_ready are both high (edge E0).
- out_valid is high after edge E0+N+1, i.e. latency N+1 cycles.
- DONE with out_ready already high: returns to IDLE on the next edge, giving a minimum issue interval of N+3 cycles.
- in_ready is 0 from E0 until the edge after the output is consumed. There is no accept in DONE, even with out_ready high.
- out_valid never drops without out_ready.

## Structure
- Package mult_pkg:
  - state enum (IDLE, BUSY, FIX, DONE) with 2-bit encoding.
  - Counter width constant, $clog2(N).
  - Overflow-check function parameterised by N.
- One sub-module, shift_add_step: combinational single iteration, mapping P and the multiplicand magnitude to the next P. It is reusable for a future radix-4 variant.
- The top level holds the FSM, counter, capture registers and output registers.

## Test plan
- N=32 signed, in1=0xFFFFFFFD (-3), in2=7 -> out=0xFFFFFFFFFFFFFFEB, ovflag=0; out_valid rises exactly 33 cycles after the accept edge.
- N=32 signed, 0x80000000 × 0x80000000 -> out=0x4000000000000000, ovflag=1. Signed 0 × 0x80000000 -> out=0, ovflag=0.
- N=32, 0xFFFFFFFF × 0xFFFFFFFF:
  - unsigned -> out=0xFFFFFFFE00000001, ovflag=1;
  - signed -> out=1, ovflag=0.
- Backpressure: hold out_ready low for 5 cycles after out_valid and pulse in_valid with new operands -> out and ovflag unchanged, in_ready=0, new operands ignored. Raise out_ready -> IDLE next edge, and a new accept completes correctly.
- Reset mid-BUSY: assert rst at iteration 10 -> out_valid=0 and out=0 immediately; after release, 5 × 6 unsigned -> out=30.
- N=8 signed, 0x7F × 0x7F -> out=0x3F01, ovflag=1, latency 9 cycles. 0x05 × 0xFD -> out=0xFFF1 (-15), ovflag=0.
